// File: rtl/memory_responder_if.sv
// Request/response bundle between a requester (instruction and data ports)
// and the single-ported memory responder.
interface memory_responder_if;
    logic        i_readM;
    logic [15:0] i_address;
    logic [15:0] i_data;
    logic        i_ready;
    logic        d_readM;
    logic        d_writeM;
    logic [15:0] d_address;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_ready;

    modport master (
        output i_readM, i_address, d_readM, d_writeM, d_address, d_wdata,
        input  i_data, i_ready, d_rdata, d_ready
    );

    modport slave (
        input  i_readM, i_address, d_readM, d_writeM, d_address, d_wdata,
        output i_data, i_ready, d_rdata, d_ready
    );
endinterface

// File: rtl/memory_responder.sv
// Single-ported 16-bit memory serving an instruction and a data port,
// one access in flight, fixed LATENCY edges from request sampling to ready.
module memory_responder #(
    parameter int LATENCY   = 2,
    parameter int ADDR_BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    memory_responder_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [3:0]             r_cnt;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [15:0]            r_wdata;
    logic                   r_write;
    logic                   r_port_d;
    logic [15:0]            r_i_data;
    logic [15:0]            r_d_rdata;
    logic [15:0]            r_mem [2**ADDR_BITS];

    logic                   w_sample_d;
    logic                   w_sample_i;
    logic                   w_busy;
    logic                   w_finish;
    logic                   w_unused;

    // Upper address bits are deliberately ignored so addresses wrap.
    assign w_unused = &{1'b0, bus.i_address, bus.d_address};

    always_comb begin
        w_sample_d = (r_state == IDLE) && (bus.d_readM || bus.d_writeM);
        w_sample_i = (r_state == IDLE) && !w_sample_d && bus.i_readM;
        w_busy     = (r_state == BUSY_I) || (r_state == BUSY_D);
        w_finish   = w_busy && (r_cnt == '0);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_sample_d)
                    w_next = BUSY_D;
                else if (w_sample_i)
                    w_next = BUSY_I;
            end
            BUSY_I,
            BUSY_D: begin
                if (r_cnt == '0)
                    w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_i_data  <= '0;
            r_d_rdata <= '0;
        end else begin
            if (w_sample_d || w_sample_i)
                r_cnt <= 4'(LATENCY - 1);
            else if (w_busy && (r_cnt != '0))
                r_cnt <= r_cnt - 4'd1;

            if (w_finish && !r_write) begin
                if (r_port_d)
                    r_d_rdata <= r_mem[r_addr];
                else
                    r_i_data  <= r_mem[r_addr];
            end
        end
    end

    // Access descriptor captured only at the sampling edge.
    always_ff @(posedge clk) begin
        if (w_sample_d || w_sample_i) begin
            r_port_d <= w_sample_d;
            r_write  <= w_sample_d && bus.d_writeM;
            r_addr   <= w_sample_d ? bus.d_address[ADDR_BITS-1:0]
                                   : bus.i_address[ADDR_BITS-1:0];
            r_wdata  <= bus.d_wdata;
        end
    end

    // Contents survive reset; a reset edge simply suppresses the commit.
    always_ff @(posedge clk) begin
        if (reset_n && w_finish && r_write)
            r_mem[r_addr] <= r_wdata;
    end

    assign bus.i_ready = (r_state == DONE) && !r_port_d;
    assign bus.d_ready = (r_state == DONE) &&  r_port_d;
    assign bus.i_data  = r_i_data;
    assign bus.d_rdata = r_d_rdata;

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning rising edges from request sampling to ready; legal range 1..15.
REQ-002 SHALL have parameter ADDR_BITS, default 8, meaning storage depth 2^ADDR_BITS words of 16 bits.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port i_readM  input  1  instruction read request, held high by requester until i_ready seen.
REQ-006 SHALL have port i_address  input  16  instruction word address.
REQ-007 SHALL have port i_data  output  16  instruction read data.
REQ-008 SHALL have port i_ready  output  1  instruction response pulse.
REQ-009 SHALL have port d_readM  input  1  data read request, held until d_ready.
REQ-010 SHALL have port d_writeM  input  1  data write request, held until d_ready.
REQ-011 SHALL have port d_address  input  16  data word address.
REQ-012 SHALL have port d_wdata  input  16  data write value.
REQ-013 SHALL have port d_rdata  output  16  data read value.
REQ-014 SHALL have port d_ready  output  1  data response pulse, for both reads and writes.

Function
REQ-015 SHALL contain one single-ported 2^ADDR_BITS x 16 array shared by both ports; at most one access in flight.
REQ-016 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, DONE.
REQ-017 In IDLE, SHALL sample requests at each edge: d_readM or d_writeM high -> BUSY_D; else i_readM high -> BUSY_I; else stay IDLE.
REQ-018 SHALL give the data port fixed priority when both ports request at the same edge; the instruction request stays pending and is sampled again on return to IDLE.
REQ-019 SHALL latch the address, d_wdata and access type at the sampling edge; input changes during BUSY_* SHALL be ignored.
REQ-020 SHALL index the array with address[ADDR_BITS-1:0]; upper bits are ignored, so addresses wrap modulo depth.
REQ-021 SHALL load a down-counter with LATENCY-1 on entry to BUSY_*, decrement each edge, and exit to DONE at the edge where the counter is 0.
REQ-022 SHALL assert the matching ready output high for exactly the one cycle spent in DONE, LATENCY edges after the sampling edge.
REQ-023 For reads, SHALL update i_data or d_rdata at the same edge ready rises, and hold the value until the next read response on that port.
REQ-024 For writes, SHALL commit d_wdata to the array at the edge ready rises; d_rdata SHALL be unchanged.
REQ-025 SHALL treat d_readM and d_writeM both high as a write.
REQ-026 SHALL go DONE -> IDLE unconditionally without sampling, so the earliest next sampling edge is LATENCY+2 edges after the previous one.
REQ-027 If a request drops during BUSY_*, SHALL still complete the access, including the write commit, and pulse ready.
REQ-028 A read issued after a write to the same address SHALL return the written value.
REQ-029 The ready outputs SHALL never be high simultaneously.

Reset
REQ-030 With reset_n low at an edge, SHALL force IDLE, counter 0, i_ready=0, d_ready=0, i_data=16'h0000, d_rdata=16'h0000.
REQ-031 Reset asserted mid-access SHALL abort it: no write commit and no ready pulse.
REQ-032 Reset SHALL NOT clear array contents.
REQ-033 SHALL sample requests starting at the first edge after reset_n goes high.

Verification (LATENCY=2, ADDR_BITS=8)
REQ-034 Write 16'hBEEF to d_address 16'h0010, sampled at edge k -> d_ready high only in the cycle after edge k+2; array[0x10]=BEEF.
REQ-035 Then d_readM at 16'h0110 (wraps to 0x10) -> d_rdata=16'hBEEF with d_ready pulse; i_data unchanged.
REQ-036 i_readM and d_readM both high at the same edge -> d_ready pulses first; i_ready pulses 4 edges later; both return correct data.
REQ-037 Write with d_readM=d_writeM=1 -> array updated, d_rdata unchanged.
REQ-038 reset_n low one edge after a write is sampled -> no d_ready, array word unchanged, outputs 0; array words not targeted retain their values.
REQ-039 Request dropped after the sampling edge -> ready still pulses; a held request is re-sampled no earlier than edge k+4.
